// File: rtl/uart_tx_fifo.sv
// Byte FIFO and send sequencer feeding the UART transmitter handshake.
// Holds each popped byte on tx_in_o for a whole frame and re-arms on each tx_done rising edge.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [7:0]    wr_data_i,
  input  logic          clr_overflow_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o,
  output logic          overflow_o,
  output logic          busy_o,
  output logic          send_o,
  output logic [7:0]    tx_in_o,
  input  logic          tx_done_i
);

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   LVL_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      tx_in_q, tx_in_d;
  logic            tx_done_q;
  logic            full, empty, push, pop, done_rise;

  assign full      = (level_q == LVL_DEPTH);
  assign empty     = (level_q == '0);
  assign push      = wr_en_i & ~full;
  assign done_rise = tx_done_i & ~tx_done_q;

  always_comb begin
    state_d = state_q;
    tx_in_d = tx_in_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          tx_in_d = mem_q[rd_ptr_q];
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (done_rise) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_ONE;
    end else if (pop && !push) begin
      level_d = level_q - LVL_ONE;
    end
    // A write attempt while full takes priority over a same-cycle clear.
    if (wr_en_i && full) begin
      overflow_d = 1'b1;
    end else if (clr_overflow_i) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      tx_in_q    <= 8'h00;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      tx_in_q    <= tx_in_d;
      tx_done_q  <= tx_done_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign full_o     = full;
  assign empty_o    = empty;
  assign level_o    = level_q;
  assign overflow_o = overflow_q;
  assign busy_o     = (state_q == ST_SEND);
  assign send_o     = (state_q == ST_SEND);
  assign tx_in_o    = tx_in_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_uart_tx_fifo;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int FRAME = 40;
  localparam int BITT  = 16;

  logic          clk = 1'b0;
  logic          rst_r = 1'b1;
  logic          wr_en_r = 1'b0;
  logic [7:0]    wr_data_r = 8'h00;
  logic          clr_r = 1'b0;
  logic          txd_r = 1'b0;
  logic          full_o, empty_o, overflow_o, busy_o, send_o;
  logic [AW:0]   level_o;
  logic [7:0]    tx_in_o;

  int checks = 0;
  int failures = 0;

  logic [7:0] mq[$];
  logic       m_send = 1'b0;
  logic [7:0] m_tx = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_txd = 1'b0;

  logic       auto_tx = 1'b0;
  int         xcnt = 0;
  logic       prev_send = 1'b0;
  int         low_run = 0;
  logic [7:0] rec[$];
  int         gaps[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_i          (rst_r),
    .wr_en_i        (wr_en_r),
    .wr_data_i      (wr_data_r),
    .clr_overflow_i (clr_r),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .level_o        (level_o),
    .overflow_o     (overflow_o),
    .busy_o         (busy_o),
    .send_o         (send_o),
    .tx_in_o        (tx_in_o),
    .tx_done_i      (txd_r)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: a byte queue, one in-flight byte and a send flag.
  task automatic model_edge();
    logic mfull, mempty, rise;
    if (rst_r) begin
      mq.delete();
      m_send = 1'b0;
      m_tx   = 8'h00;
      m_ovf  = 1'b0;
      m_txd  = 1'b0;
      return;
    end
    mfull  = (mq.size() == DEPTH);
    mempty = (mq.size() == 0);
    rise   = txd_r && !m_txd;
    if (wr_en_r && mfull) m_ovf = 1'b1;
    else if (clr_r) m_ovf = 1'b0;
    if (!m_send && !mempty) begin
      m_tx   = mq.pop_front();
      m_send = 1'b1;
    end else if (m_send && rise) begin
      m_send = 1'b0;
    end
    if (wr_en_r && !mfull) mq.push_back(wr_data_r);
    m_txd = txd_r;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("send",     send_o,     m_send);
    check("busy",     busy_o,     m_send);
    check("tx_in",    tx_in_o,    m_tx);
    check("level",    level_o,    mq.size());
    check("empty",    empty_o,    mq.size() == 0);
    check("full",     full_o,     mq.size() == DEPTH);
    check("overflow", overflow_o, m_ovf);
    if (send_o && !prev_send) begin
      rec.push_back(tx_in_o);
      gaps.push_back(low_run);
    end
    low_run   = send_o ? 0 : low_run + 1;
    prev_send = send_o;
    if (auto_tx) begin
      if (xcnt == 0) begin
        txd_r = 1'b0;
        if (send_o) xcnt = 1;
      end else begin
        xcnt++;
        txd_r = (xcnt > FRAME);
        if (xcnt > FRAME + BITT) begin
          xcnt  = 0;
          txd_r = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_r = 1'b1; wr_en_r = 1'b0; clr_r = 1'b0; txd_r = 1'b0;
    cyc();
    rst_r = 1'b0;
  endtask

  initial begin
    int pct;
    // Reset then idle
    do_reset();
    repeat (20) cyc();
    check("idle_send",  send_o,     1'b0);
    check("idle_empty", empty_o,    1'b1);
    check("idle_level", level_o,    0);
    check("idle_tx_in", tx_in_o,    8'h00);
    check("idle_ovf",   overflow_o, 1'b0);

    // Single byte, two-edge latency, long tx_done level
    wr_en_r = 1'b1; wr_data_r = 8'hA5;
    cyc();
    wr_en_r = 1'b0;
    check("single_e0_send", send_o, 1'b0);
    cyc();
    check("single_e1_send",  send_o,  1'b1);
    check("single_e1_tx",    tx_in_o, 8'hA5);
    check("single_e1_level", level_o, 0);
    txd_r = 1'b1;
    cyc();
    check("single_done_send", send_o, 1'b0);
    repeat (49) cyc();
    check("single_hold_send", send_o,  1'b0);
    check("single_hold_tx",   tx_in_o, 8'hA5);
    txd_r = 1'b0;
    repeat (3) cyc();

    // Burst ordering with a behavioural transmitter
    do_reset();
    rec.delete(); gaps.delete(); low_run = 0; prev_send = 1'b0; xcnt = 0; auto_tx = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wr_en_r = 1'b1; wr_data_r = 8'(i);
      cyc();
    end
    wr_en_r = 1'b0;
    repeat (250) cyc();
    auto_tx = 1'b0; txd_r = 1'b0;
    check("burst_frames", rec.size(), 3);
    for (int i = 0; i < 3; i++)
      check("burst_byte", (i < rec.size()) ? 32'(rec[i]) : 32'hFFFF, 32'(i + 1));
    for (int i = 1; i < 3; i++)
      check("burst_gap", (i < gaps.size()) ? gaps[i] : -1, 1);
    cyc();

    // Full / overflow with tx_done low
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      wr_en_r = 1'b1; wr_data_r = 8'(8'h10 + i);
      cyc();
    end
    wr_en_r = 1'b0;
    check("full_level", level_o,    4);
    check("full_flag",  full_o,     1'b1);
    check("full_ovf",   overflow_o, 1'b1);
    check("full_tx",    tx_in_o,    8'h11);
    wr_en_r = 1'b1; wr_data_r = 8'h99; clr_r = 1'b1;
    cyc();
    check("ovf_set_wins", overflow_o, 1'b1);
    wr_en_r = 1'b0;
    cyc();
    check("ovf_cleared", overflow_o, 1'b0);
    clr_r = 1'b0;

    // Pop and write on the same edge while full
    txd_r = 1'b1;
    cyc();
    check("pw_done_send",  send_o,  1'b0);
    check("pw_done_level", level_o, 4);
    wr_en_r = 1'b1; wr_data_r = 8'h77;
    cyc();
    wr_en_r = 1'b0;
    check("pw_level", level_o,    3);
    check("pw_ovf",   overflow_o, 1'b1);
    check("pw_send",  send_o,     1'b1);
    check("pw_tx",    tx_in_o,    8'h12);
    for (int k = 0; k < 4; k++) begin
      txd_r = 1'b0; cyc();
      txd_r = 1'b1; cyc();
    end
    txd_r = 1'b0;
    cyc();

    // Reset mid-frame
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr_en_r = 1'b1; wr_data_r = 8'(8'hC0 + i);
      cyc();
    end
    wr_en_r = 1'b0;
    check("mid_send_before", send_o, 1'b1);
    rst_r = 1'b1;
    cyc();
    rst_r = 1'b0;
    check("mid_send",  send_o,  1'b0);
    check("mid_level", level_o, 0);
    check("mid_empty", empty_o, 1'b1);
    repeat (10) cyc();
    check("mid_quiet", send_o, 1'b0);

    // Random traffic
    pct = 50;
    for (int n = 0; n < 4000; n++) begin
      if (n % 500 == 0) pct = $urandom_range(10, 95);
      rst_r     = ($urandom_range(0, 599) == 0);
      wr_en_r   = ($urandom_range(0, 99) < pct);
      wr_data_r = 8'($urandom);
      clr_r     = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 5) == 0) txd_r = ~txd_r;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer and send sequencer in front of the UART transmitter. Accepts bytes from the system side through a write strobe, stores up to DEPTH of them, and presents them one at a time to the transmitter's `send`/`tx_in`/`tx_done` handshake. It holds each byte stable for a whole frame and re-arms on each `tx_done` rising edge. It runs entirely on the system clock; the transmitter's baud-rate timing is tracked only through `tx_done`.

## Interface
Parameters:
- DEPTH, 16, FIFO capacity in bytes; power of two, ≥2. AW = log2(DEPTH).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  one clock; reset is synchronous and active-high.
- wr_en  in  1  write strobe, one byte per cycle while high.
- wr_data  in  8  byte to enqueue, sampled when wr_en=1.
- clr_overflow  in  1  clears the overflow flag.
- full  out  1  FIFO holds DEPTH bytes.
- empty  out  1  FIFO holds 0 bytes.
- level  out  AW+1  bytes currently stored, 0..DEPTH; excludes the byte being transmitted.
- overflow  out  1  sticky; set by a write while full.
- busy  out  1  sequencer in SEND state.
- send  out  1  transmit request to the transmitter.
- tx_in  out  8  byte presented to the transmitter.
- tx_done  in  1  transmitter frame-complete level (high for about one bit time).

## Operation
- Storage: circular buffer, DEPTH×8, with AW-bit read and write pointers that wrap from DEPTH-1 to 0. Occupancy is held in the level register.
- Write: when wr_en=1 and full=0, store wr_data at wr_ptr, increment wr_ptr and level.
- Write while full: data dropped, pointers unchanged, overflow set. This applies even if a pop happens the same cycle, because `full` is the registered pre-edge value.
- Pop and write in the same cycle: level unchanged, both pointers advance.
- overflow: cleared by clr_overflow. If set and clear occur in the same cycle, set wins.
- Edge detect: register tx_done_q <= tx_done. done_rise = tx_done & ~tx_done_q.
- FSM states:
  - IDLE: send=0. If empty=0: pop the head into the tx_in register, send<=1, go to SEND. Otherwise stay.
  - SEND: send=1 and tx_in held constant. On done_rise: send<=0, go to IDLE. Otherwise stay; no timeout.
- tx_in changes only on a pop and keeps its last value while in IDLE.
- A high tx_done already present on entry to SEND does not complete the frame; only a new rising edge does.
- Reset values: state IDLE, pointers 0, level 0, empty=1, full=0, overflow=0, busy=0, send=0, tx_in=8'h00, tx_done_q=0. Buffer contents are not reset.
- Reset mid-frame: all queued bytes are discarded and send drops on the reset edge. The transmitter shares rst, so no partial frame resumes.

## Timing
- empty, full, level: registered; they reflect the write or pop on the edge that performs it.
- Write-to-send latency into an empty idle FIFO: wr_en sampled at edge E0 makes empty=0. At E1 the FSM pops, and send=1 with valid tx_in after E1. Minimum 2 edges.
- Frame completion: done_rise is sampled at edge Ed and send=0 after Ed.
- Back-to-back: if the FIFO is non-empty, the next pop happens at Ed+1 and send=1 again after it. That gives exactly one cycle of send=0 between frames.
- The gap is far shorter than one bit time, so the transmitter's next idle check sees send=1. Frames go out back-to-back with only the stop bit between them.
- A byte being transmitted does not count toward level. Total storage is DEPTH+1 bytes (DEPTH queued plus 1 in flight).

## Test plan
- Reset then idle: after rst, hold for 20 cycles. Expect send=0, empty=1, level=0, tx_in=8'h00, overflow=0.
- Single byte: write 8'hA5 to an empty FIFO. Expect send=1 and tx_in=8'hA5 two edges after the write, and level back to 0. Pulse tx_done high for 50 cycles: send=0 one edge after its rise, and send stays 0 afterwards.
- Burst ordering with the real transmitter (freq/baud small, e.g. count=16): write 8'h01, 8'h02, 8'h03 on consecutive cycles. Expect the tx line to carry three frames LSB-first in order 01, 02, 03, with one send-low cycle between them.
- Full/overflow: DEPTH=4 with tx_done held low. Write 6 bytes.
  - Byte 1 is popped into SEND; bytes 2–5 fill the FIFO (full=1, level=4); byte 6 sets overflow.
  - Pulse clr_overflow together with another write while full: overflow stays 1 (set wins). A lone clr_overflow then clears it.
- Simultaneous pop and write at full: DEPTH=4, full. Generate done_rise, then write 8'h77 on the pop edge. Expect the write dropped, overflow=1, and level=3 afterwards.
- Reset mid-frame: queue 3 bytes, assert rst while send=1. Expect send=0, level=0, empty=1 after the reset edge, and no further send until a new write.
